// File: rtl/rom_block_loader.sv
// rom_block_loader: copies a block of words from the ROM bus slave into a
// destination write port, one outstanding request at a time.
// Optional build macro: ROM_LDR_TIMEOUT_EN adds a WAIT-cycle timeout that
// aborts the block and raises a sticky err flag.
module rom_block_loader #(
   parameter int ADDR_W      = 11,
   parameter int DATA_W      = 32,
   parameter int DST_W       = 12,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [DST_W-1:0]  dst_addr,
   input  logic [ADDR_W:0]   len,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              cs_,
   output logic              as_,
   output logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] rd_data,
   input  logic              rdy_,
   output logic              wr_en,
   output logic [DST_W-1:0]  wr_addr,
   output logic [DATA_W-1:0] wr_data
);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, WRITE, FIN} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] src_q;
   logic [DST_W-1:0]  dst_q;
   logic [ADDR_W:0]   rem_q;
   logic [DATA_W-1:0] data_q;
   logic              timeout;

`ifdef ROM_LDR_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] wait_cnt;
   logic             err_q;

   // Count WAIT cycles for the current word; restarted by every request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt <= '0;
      end else if (state == REQ) begin
         wait_cnt <= '0;
      end else if (state == WAIT && rdy_) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   // Timeout fires on the last allowed WAIT cycle with the ROM still not ready.
   assign timeout = (state == WAIT) && rdy_ && (wait_cnt == CNT_LAST);

   // Sticky abort flag, cleared only when a new transfer is accepted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_q <= 1'b0;
      end else if (state == IDLE && start) begin
         err_q <= 1'b0;
      end else if (timeout) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   assign timeout = 1'b0;
   assign err     = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic; remaining count is checked before its decrement lands.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (len == '0) ? FIN : REQ;
         REQ:     state_nxt = WAIT;
         WAIT: begin
            if (!rdy_)        state_nxt = WRITE;
            else if (timeout) state_nxt = FIN;
         end
         WRITE:   state_nxt = (rem_q == 1) ? FIN : REQ;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Transfer bookkeeping: latch on start, capture read data, step after a write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         src_q  <= '0;
         dst_q  <= '0;
         rem_q  <= '0;
         data_q <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               src_q <= src_addr;
               dst_q <= dst_addr;
               rem_q <= len;
            end
            WAIT: if (!rdy_) data_q <= rd_data;
            WRITE: begin
               src_q <= src_q + 1'b1;
               dst_q <= dst_q + 1'b1;
               rem_q <= rem_q - 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Bus strobes and status decode straight from state, so reset clears them at once.
   always_comb begin
      busy  = (state != IDLE);
      done  = (state == FIN);
      cs_   = (state != REQ);
      as_   = (state != REQ);
      wr_en = (state == WRITE);
   end

   assign addr    = src_q;
   assign wr_addr = dst_q;
   assign wr_data = data_q;

endmodule

// File: tb/tb_rom_block_loader.sv
// Directed bench for rom_block_loader: table of block transfers against a
// ROM model with programmable latency, plus reset and start-ignore sequences.
module tb_rom_block_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [10:0] src_addr = '0;
   logic [11:0] dst_addr = '0;
   logic [11:0] len = '0;
   logic        busy, done, err, cs_, as_, wr_en, rdy_;
   logic [10:0] addr;
   logic [11:0] wr_addr;
   logic [31:0] wr_data, rd_data;

   rom_block_loader dut (
      .clk(clk), .reset(reset), .start(start), .src_addr(src_addr),
      .dst_addr(dst_addr), .len(len), .busy(busy), .done(done), .err(err),
      .cs_(cs_), .as_(as_), .addr(addr), .rd_data(rd_data), .rdy_(rdy_),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   function automatic logic [31:0] mem(input logic [10:0] a);
      logic [31:0] t;
      t = {21'b0, a};
      return t * 32'h1111_1111;
   endfunction

   // ROM model: ready goes low 'lat' cycles after the request (lat=0: never).
   int          lat = 1;
   int          rom_cnt = 0;
   logic [10:0] rom_a = '0;
   always @(posedge clk or posedge reset) begin
      if (reset) rom_cnt <= 0;
      else if (!cs_ && !as_) begin
         rom_cnt <= lat;
         rom_a   <= addr;
      end else if (rom_cnt != 0) rom_cnt <= rom_cnt - 1;
   end
   assign rdy_    = !(rom_cnt == 1);
   assign rd_data = mem(rom_a);

   // Bus activity log.
   logic        log_en = 1'b0;
   logic [11:0] wq_a[$];
   logic [31:0] wq_d[$];
   logic [10:0] rq[$];
   always @(negedge clk) begin
      if (log_en) begin
         if (wr_en) begin
            wq_a.push_back(wr_addr);
            wq_d.push_back(wr_data);
         end
         if (!cs_ || !as_) rq.push_back(addr);
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic [10:0] src;
      logic [11:0] dst;
      logic [11:0] len;
      int          lat;
      int          cyc;
      logic        exp_err;
      int          exp_wr;
   } vec_t;

   // Pulse start and follow one transfer to done, then compare the logs.
   task automatic run_xfer(input vec_t v, input string nm);
      int   cyc;
      logic got;
      wq_a.delete(); wq_d.delete(); rq.delete();
      lat = v.lat;
      log_en = 1'b1;
      @(negedge clk);
      src_addr = v.src; dst_addr = v.dst; len = v.len; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      cyc = 0; got = 1'b0;
      while (!got && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) chk({nm, " busy"}, busy, 1'b1);
         if (done) got = 1'b1;
      end
      chk({nm, " done_cycle"}, cyc, v.cyc);
      chk({nm, " err"}, err, v.exp_err);
      @(negedge clk);
      chk({nm, " idle_after"}, {busy, done}, 2'b00);
      log_en = 1'b0;
      chk({nm, " n_writes"}, wq_a.size(), v.exp_wr);
      chk({nm, " n_reqs"}, rq.size(), (v.len == 0) ? 0 : (v.exp_wr + (v.exp_err ? 1 : 0)));
      for (int i = 0; i < wq_a.size() && i < v.exp_wr; i++) begin
         logic [11:0] ea;
         logic [10:0] sa;
         ea = v.dst + i[11:0];
         sa = v.src + i[10:0];
         chk($sformatf("%s wr_addr[%0d]", nm, i), wq_a[i], ea);
         chk($sformatf("%s wr_data[%0d]", nm, i), wq_d[i], mem(sa));
         if (i < rq.size()) chk($sformatf("%s req_addr[%0d]", nm, i), rq[i], sa);
      end
   endtask

   vec_t vecs[6];

   initial begin
      int ndone;
      vecs[0] = '{11'h010, 12'h020, 12'd4,    1, 13,   1'b0, 4};
      vecs[1] = '{11'h000, 12'h000, 12'd0,    1, 1,    1'b0, 0};
      vecs[2] = '{11'h7FE, 12'hFFF, 12'd3,    1, 10,   1'b0, 3};
      vecs[3] = '{11'h020, 12'h100, 12'd2,    5, 15,   1'b0, 2};
      vecs[4] = '{11'h003, 12'h007, 12'd1,    2, 5,    1'b0, 1};
      vecs[5] = '{11'h000, 12'h800, 12'd2048, 1, 6145, 1'b0, 2048};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset state", {busy, done, err, cs_, as_, addr, wr_en, wr_addr, wr_data},
          {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 11'h0, 1'b0, 12'h0, 32'h0});
      reset = 1'b0;

      for (int i = 0; i < 6; i++) run_xfer(vecs[i], $sformatf("vec%0d", i));

      // Reset during WAIT of word 2 (lat=3: word 2 WAIT spans cycles 7..9).
      lat = 3;
      @(negedge clk);
      src_addr = 11'h100; dst_addr = 12'h055; len = 12'd4; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (7) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("mid reset outputs", {busy, done, err, cs_, as_, addr, wr_en, wr_addr, wr_data},
          {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 11'h0, 1'b0, 12'h0, 32'h0});
      repeat (2) @(negedge clk);
      reset = 1'b0;
      ndone = 0;
      repeat (12) begin
         @(negedge clk);
         if (done || busy) ndone++;
      end
      chk("no done after reset", ndone, 0);
      run_xfer(vecs[0], "post_reset");

      // Start while busy and start coincident with done are both ignored.
      lat = 1;
      @(negedge clk);
      src_addr = 11'h005; dst_addr = 12'h009; len = 12'd1; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      src_addr = 11'h200; len = 12'd0; start = 1'b1;   // cycle 2, busy
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      chk("busy start ignored wr", {wr_en, wr_addr, wr_data}, {1'b1, 12'h009, mem(11'h005)});
      @(negedge clk);
      chk("done cycle 4", done, 1'b1);
      start = 1'b1;                                    // during FIN
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      chk("fin start ignored", busy, 1'b0);

`ifdef ROM_LDR_TIMEOUT_EN
      run_xfer('{11'h040, 12'h010, 12'd2, 0, 18, 1'b1, 0}, "timeout");
      run_xfer('{11'h041, 12'h011, 12'd1, 1, 4, 1'b0, 1}, "after_timeout");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule
